// File: rtl/exec_pkg.sv
// Shared definitions for the exec sequencer: opcodes, FSM states, default widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package exec_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADRS_WIDTH_DEF = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: add/sub/logic/shift/compare with carry (borrow for sub/cmp).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            opcode,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  carry
);

  logic [DATA_WIDTH:0] sum;

  // Select the operation; carry is the add carry-out or the subtract borrow.
  always_comb begin
    y     = '0;
    carry = 1'b0;
    sum   = '0;
    case (opcode)
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        y     = sum[DATA_WIDTH-1:0];
        carry = sum[DATA_WIDTH];
      end
      OP_SUB, OP_CMP: begin
        y     = a - b;
        carry = (a < b);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: y = a << b[3:0];
      OP_SHR: y = a >> b[3:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Four-state sequencer driving a register file and ALU (IDLE/READ/EXEC/WRITE); flags gated by EXEC_FLAGS_EN.
// Latency: done pulses in the third cycle after the accepting edge; one instruction per 4 cycles.
// Backpressure: instr_ready high only in IDLE; inputs are ignored everywhere else.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADRS_WIDTH = ADRS_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            opcode,
  input  logic [ADRS_WIDTH-1:0] rd_adrs,
  input  logic [ADRS_WIDTH-1:0] ra_adrs,
  input  logic [ADRS_WIDTH-1:0] rb_adrs,
  output logic                  rf_enable,
  output logic                  rf_wr_en,
  output logic [ADRS_WIDTH-1:0] rf_rd_adrs,
  output logic [ADRS_WIDTH-1:0] rf_ra_adrs,
  output logic [ADRS_WIDTH-1:0] rf_rb_adrs,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  input  logic [DATA_WIDTH-1:0] rf_ra_out,
  input  logic [DATA_WIDTH-1:0] rf_rb_out,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero_flag,
  output logic                  carry_flag
);

  state_t                state;
  logic [2:0]            op_q;
  logic [ADRS_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] alu_y;
  logic                  alu_carry;

  // Operands come straight from the register file's registered read ports.
  exec_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (rf_ra_out),
    .b      (rf_rb_out),
    .opcode (op_q),
    .y      (alu_y),
    .carry  (alu_carry)
  );

`ifndef EXEC_FLAGS_EN
  logic flags_unused;
  assign flags_unused = alu_carry;
  assign zero_flag    = 1'b0;
  assign carry_flag   = 1'b0;
`endif

  // Sequencer FSM: every output is registered and set up one state ahead.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      instr_ready <= 1'b1;
      op_q        <= '0;
      rd_q        <= '0;
      rf_enable   <= 1'b0;
      rf_wr_en    <= 1'b0;
      rf_rd_adrs  <= '0;
      rf_ra_adrs  <= '0;
      rf_rb_adrs  <= '0;
      rf_data_in  <= '0;
      done        <= 1'b0;
      result      <= '0;
`ifdef EXEC_FLAGS_EN
      zero_flag   <= 1'b0;
      carry_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (instr_valid && instr_ready) begin
            op_q        <= opcode;
            rd_q        <= rd_adrs;
            rf_ra_adrs  <= ra_adrs;
            rf_rb_adrs  <= rb_adrs;
            rf_enable   <= 1'b1;
            rf_wr_en    <= 1'b0;
            instr_ready <= 1'b0;
            state       <= ST_READ;
          end
        end
        ST_READ: begin
          // Register file captures operands on this closing edge.
          rf_enable <= 1'b0;
          state     <= ST_EXEC;
        end
        ST_EXEC: begin
          result     <= alu_y;
          rf_data_in <= alu_y;
          rf_rd_adrs <= rd_q;
`ifdef EXEC_FLAGS_EN
          zero_flag  <= (alu_y == '0);
          carry_flag <= alu_carry;
`endif
          // CMP only updates flags; it never touches the register file.
          rf_enable  <= (op_q != OP_CMP);
          rf_wr_en   <= (op_q != OP_CMP);
          done       <= 1'b1;
          state      <= ST_WRITE;
        end
        ST_WRITE: begin
          rf_enable   <= 1'b0;
          rf_wr_en    <= 1'b0;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench: accepted instructions are modelled arithmetically and queued; a monitor checks each done.
// Includes a behavioural 8x16 register file with registered read ports and a preload port.
// Flag expectations follow EXEC_FLAGS_EN.
module tb_exec_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  opcode = '0;
  logic [2:0]  rd_adrs = '0;
  logic [2:0]  ra_adrs = '0;
  logic [2:0]  rb_adrs = '0;
  logic        rf_enable;
  logic        rf_wr_en;
  logic [2:0]  rf_rd_adrs;
  logic [2:0]  rf_ra_adrs;
  logic [2:0]  rf_rb_adrs;
  logic [15:0] rf_data_in;
  logic [15:0] rf_ra_out = '0;
  logic [15:0] rf_rb_out = '0;
  logic        done;
  logic [15:0] result;
  logic        zero_flag;
  logic        carry_flag;

`ifdef EXEC_FLAGS_EN
  localparam int FL = 1;
`else
  localparam int FL = 0;
`endif

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        we;
    logic [2:0]  rd;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_regs [8];
  logic [15:0] rf_mem [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_adrs = '0;
  logic [15:0] pre_dat = '0;
  int          cyc = 0;
  int          acc_count = 0;
  int          last_acc = 0;
  int          checks = 0;
  int          errors = 0;

  exec_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .rd_adrs     (rd_adrs),
    .ra_adrs     (ra_adrs),
    .rb_adrs     (rb_adrs),
    .rf_enable   (rf_enable),
    .rf_wr_en    (rf_wr_en),
    .rf_rd_adrs  (rf_rd_adrs),
    .rf_ra_adrs  (rf_ra_adrs),
    .rf_rb_adrs  (rf_rb_adrs),
    .rf_data_in  (rf_data_in),
    .rf_ra_out   (rf_ra_out),
    .rf_rb_out   (rf_rb_out),
    .done        (done),
    .result      (result),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag)
  );

  always #5 clock = ~clock;

  // Register file: synchronous write, registered reads, bench preload port.
  always @(posedge clock) begin
    if (pre_we)
      rf_mem[pre_adrs] <= pre_dat;
    else if (rf_enable && rf_wr_en)
      rf_mem[rf_rd_adrs] <= rf_data_in;
    else if (rf_enable) begin
      rf_ra_out <= rf_mem[rf_ra_adrs];
      rf_rb_out <= rf_mem[rf_rb_adrs];
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", nm, act, exp_v, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL timeout_%s at cycle %0d", nm, cyc);
  endtask

  // Reference model: results straight from the opcode table, using integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [2:0] rd,
                                 input logic [15:0] a, input logic [15:0] b, input int acc);
    exp_t e;
    int   s;
    int   ia = int'(a);
    int   ib = int'(b);
    int   sh = int'(b[3:0]);
    e.we = 1'b1; e.c = 1'b0; e.rd = rd; e.acc = acc; s = 0;
    case (op)
      3'd0: begin s = ia + ib; e.c = (s > 65535); end
      3'd1: begin s = ia - ib; e.c = (ia < ib); end
      3'd2: s = ia & ib;
      3'd3: s = ia | ib;
      3'd4: s = ia ^ ib;
      3'd5: s = ia << sh;
      3'd6: s = ia >> sh;
      default: begin s = ia - ib; e.c = (ia < ib); e.we = 1'b0; end
    endcase
    e.res = s[15:0];
    e.z   = (e.res == 16'h0000);
    if (FL == 0) begin
      e.z = 1'b0;
      e.c = 1'b0;
    end
    return e;
  endfunction

  // Acceptance observer: predict the response at the accepting edge.
  initial forever begin
    @(posedge clock);
    if (reset_n && instr_valid && instr_ready) begin
      sb.push_back(model(opcode, rd_adrs, ref_regs[ra_adrs], ref_regs[rb_adrs], cyc));
      acc_count++;
      last_acc = cyc;
    end
    cyc++;
  end

  // Monitor: on every done, pop the oldest prediction and compare.
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        timeout("unexpected_done");
      end else begin
        e = sb.pop_front();
        chk("latency", cyc - e.acc, 3);
        chk("result", int'(result), int'(e.res));
        chk("rf_data_in", int'(rf_data_in), int'(e.res));
        chk("zero_flag", int'(zero_flag), int'(e.z));
        chk("carry_flag", int'(carry_flag), int'(e.c));
        chk("rf_enable_write", int'(rf_enable), int'(e.we));
        chk("rf_wr_en_write", int'(rf_wr_en), int'(e.we));
        if (e.we) begin
          chk("rf_rd_adrs", int'(rf_rd_adrs), int'(e.rd));
          ref_regs[e.rd] = e.res;
        end
      end
    end
  end

  task automatic preload(input logic [2:0] adr, input logic [15:0] val);
    @(negedge clock);
    pre_we = 1'b1; pre_adrs = adr; pre_dat = val;
    @(negedge clock);
    pre_we = 1'b0;
    ref_regs[adr] = val;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb);
    int start = acc_count;
    int n = 0;
    @(negedge clock);
    opcode = op; rd_adrs = rd; ra_adrs = ra; rb_adrs = rb;
    instr_valid = 1'b1;
    while (acc_count == start && n < 40) begin
      @(negedge clock);
      n++;
    end
    instr_valid = 1'b0;
    if (acc_count == start) timeout("issue");
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !instr_ready) && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0 || !instr_ready) timeout("idle");
    @(negedge clock);
  endtask

  task automatic wait_acc(input int target, input string nm);
    int n = 0;
    while (acc_count < target && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (acc_count < target) timeout(nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c1;
    int c2;
    int start;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_rf_enable", int'(rf_enable), 0);
    chk("rst_rf_wr_en", int'(rf_wr_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({zero_flag, carry_flag}), 0);
    chk("rst_data_in", int'(rf_data_in), 0);
    chk("rst_adrs", int'({rf_rd_adrs, rf_ra_adrs, rf_rb_adrs}), 0);
    reset_n = 1'b1;
    #1;
    chk("ready_after_reset", int'(instr_ready), 1);

    for (int i = 0; i < 8; i++) preload(3'(i), 16'h0000);
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);

    // ADD R3 = R1 + R2
    issue(3'd0, 3'd3, 3'd1, 3'd2);
    wait_idle();
    chk("add_r3", int'(rf_mem[3]), 16'h0008);
    chk("add_zero", int'(zero_flag), 0);
    chk("add_carry", int'(carry_flag), 0);

    // CMP R2 vs R1: borrow, no writeback
    issue(3'd7, 3'd0, 3'd2, 3'd1);
    wait_idle();
    chk("cmp_carry", int'(carry_flag), FL);
    chk("cmp_zero", int'(zero_flag), 0);
    chk("cmp_r0_kept", int'(rf_mem[0]), 0);

    // ADD wraparound: 0xFFFF + 1
    preload(3'd1, 16'hFFFF);
    preload(3'd2, 16'h0001);
    issue(3'd0, 3'd4, 3'd1, 3'd2);
    wait_idle();
    chk("ovf_r4", int'(rf_mem[4]), 0);
    chk("ovf_zero", int'(zero_flag), FL);
    chk("ovf_carry", int'(carry_flag), FL);

    // SHL R1 = R1 << R2 with valid held; next ADD follows 4 cycles later
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    start = acc_count;
    @(negedge clock);
    opcode = 3'd5; rd_adrs = 3'd1; ra_adrs = 3'd1; rb_adrs = 3'd2;
    instr_valid = 1'b1;
    wait_acc(start + 1, "b2b_first");
    c1 = last_acc;
    opcode = 3'd0; rd_adrs = 3'd6; ra_adrs = 3'd1; rb_adrs = 3'd2;
    wait_acc(start + 2, "b2b_second");
    c2 = last_acc;
    instr_valid = 1'b0;
    chk("b2b_interval", c2 - c1, 4);
    wait_idle();
    chk("shl_r1", int'(rf_mem[1]), 16'h0028);
    chk("b2b_r6", int'(rf_mem[6]), 16'h002B);

    // Reset during EXEC of SUB R5 abandons the instruction
    issue(3'd1, 3'd5, 3'd1, 3'd2);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_result", int'(result), 0);
    chk("arst_rf_enable", int'(rf_enable), 0);
    chk("arst_rf_wr_en", int'(rf_wr_en), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_adrs", int'({rf_rd_adrs, rf_ra_adrs, rf_rb_adrs}), 0);
    chk("arst_data_in", int'(rf_data_in), 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("arst_ready", int'(instr_ready), 1);
    repeat (5) @(negedge clock);
    chk("arst_r5_kept", int'(rf_mem[5]), 0);
    chk("arst_no_done", int'(sb.size()), 0);

    // Randomized instructions with occasional preloads and idle gaps
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0)
        preload(3'($urandom_range(0, 7)), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      wait_idle();
    end

    for (int i = 0; i < 8; i++) chk($sformatf("final_r%0d", i), int'(rf_mem[i]), int'(ref_regs[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
